// File: rtl/cpu_run_controller.sv
// Execution sequencer for the 16-bit CPU: debounced step/run buttons, single-step,
// divided free-run and a one-address PC breakpoint, with a cpu_en pulse counter.
module cpu_run_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 25000000,
  parameter int DIV_WIDTH       = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_btn,
  input  logic        run_btn,
  input  logic        bp_enable,
  input  logic [15:0] bp_addr,
  input  logic [15:0] pc,
  output logic        cpu_en,
  output logic        halted,
  output logic [1:0]  state,
  output logic [31:0] cycle_count
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_STEP  = 2'b01,
    S_RUN   = 2'b10,
    S_BREAK = 2'b11
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DB_LAST  = DIV_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(RUN_DIV - 1);

  // Button index 0 is step, index 1 is run.
  logic [1:0]           btn;
  logic [1:0]           sync_p0;
  logic [1:0]           sync_p1;
  logic [1:0]           level;
  logic [1:0]           press;
  logic [DIV_WIDTH-1:0] db_cnt [2];

  state_t               fsm;
  logic [DIV_WIDTH-1:0] div;
  logic                 bp_skip;
  logic                 step_press;
  logic                 run_press;
  logic                 tick;
  logic                 bp_hit;

  assign btn = {run_btn, step_btn};

  // Stage p0/p1: two-flop synchronizer, then debounce; press is a registered
  // one-cycle pulse produced on the same edge the debounced level rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      level   <= '0;
      press   <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync_p1[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          level[i]  <= sync_p1[i];
          press[i]  <= sync_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign step_press = press[0];
  assign run_press  = press[1];

  assign tick   = (fsm == S_RUN) && (div == DIV_LAST);
  assign bp_hit = tick && bp_enable && (pc == bp_addr) && !bp_skip;

  // A halting run press or a breakpoint hit swallows the tick's advance.
  assign cpu_en = !reset &&
                  ((fsm == S_STEP) || (tick && !run_press && !bp_hit));

  assign state = fsm;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm         <= S_HALT;
      halted      <= 1'b1;
      div         <= '0;
      bp_skip     <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (cpu_en) begin
        cycle_count <= cycle_count + 32'd1;
      end
      case (fsm)
        S_HALT: begin
          if (run_press) begin
            fsm    <= S_RUN;
            div    <= '0;
            halted <= 1'b0;
          end else if (step_press) begin
            fsm    <= S_STEP;
            halted <= 1'b0;
          end
        end
        S_STEP: begin
          fsm    <= S_HALT;
          halted <= 1'b1;
        end
        S_RUN: begin
          if (tick) begin
            bp_skip <= 1'b0;
          end
          if (run_press) begin
            fsm    <= S_HALT;
            div    <= '0;
            halted <= 1'b1;
          end else begin
            div <= tick ? '0 : div + 1'b1;
            if (bp_hit) begin
              fsm    <= S_BREAK;
              halted <= 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (run_press) begin
            fsm     <= S_RUN;
            div     <= '0;
            bp_skip <= 1'b1;
            halted  <= 1'b0;
          end else if (step_press) begin
            fsm    <= S_STEP;
            halted <= 1'b0;
          end
        end
        default: begin
          fsm    <= S_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller: the bench acts as the CPU (pc advances
// after each cpu_en) and checks every pulse against a queue of expected pulses.
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step_btn = 1'b0;
  logic        run_btn = 1'b0;
  logic        bp_enable = 1'b0;
  logic [15:0] bp_addr = 16'h0000;
  logic [15:0] pc = 16'h0000;
  logic        cpu_en;
  logic        halted;
  logic [1:0]  state;
  logic [31:0] cycle_count;

  typedef struct packed {
    logic [15:0] pc;
    logic [1:0]  st;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          en_total = 0;
  int          pc_base = 0;
  logic [15:0] exp_pc = 16'h0000;
  logic [31:0] exp_cnt = 32'd0;

  cpu_run_controller #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV(3),
    .DIV_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .step_btn(step_btn),
    .run_btn(run_btn),
    .bp_enable(bp_enable),
    .bp_addr(bp_addr),
    .pc(pc),
    .cpu_en(cpu_en),
    .halted(halted),
    .state(state),
    .cycle_count(cycle_count)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_pulse(input logic [1:0] st);
    exp_t e;
    e.pc  = exp_pc;
    e.st  = st;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
    exp_pc  = exp_pc + 16'd1;
    exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every cpu_en seen mid-cycle must match the head of the queue.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (cpu_en === 1'b1) begin
      en_total++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cpu_en: pulse at pc 0x%0h state %0b, expected no pulse", pc, state);
      end else begin
        e = exp_q.pop_front();
        check("pulse_pc", 32'(pc), 32'(e.pc));
        check("pulse_state", 32'(state), 32'(e.st));
        check("pulse_count", cycle_count, e.cnt);
      end
    end
  end

  // CPU model: pc advances on the edge that consumes a cpu_en.
  initial forever begin
    @(posedge clk);
    #1;
    pc = 16'(en_total - pc_base);
  end

  initial begin
    // Reset
    @(negedge clk);
    check("reset_cpu_en", 32'(cpu_en), 32'd0);
    check("reset_state", 32'(state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cycles(20);
    check("idle_state", 32'(state), 32'd0);
    check("idle_halted", 32'(halted), 32'd1);
    check("idle_cpu_en", 32'(cpu_en), 32'd0);
    check("idle_count", cycle_count, 32'd0);

    // Held step button: one pulse, seven edges after the rise
    expect_pulse(2'b01);
    step_btn = 1'b1;
    cycles(6);
    check("step_pre_state", 32'(state), 32'd0);
    cycles(1);
    check("step_state", 32'(state), 32'd1);
    cycles(1);
    check("step_post_state", 32'(state), 32'd0);
    check("step_count", cycle_count, 32'd1);
    cycles(92);
    step_btn = 1'b0;
    cycles(20);
    expect_pulse(2'b01);
    step_btn = 1'b1;
    cycles(10);
    step_btn = 1'b0;
    cycles(20);
    check("step2_count", cycle_count, 32'd2);
    check("step2_queue", exp_q.size(), 32'd0);

    // Glitches shorter than the debounce window
    step_btn = 1'b1;
    cycles(2);
    step_btn = 1'b0;
    cycles(20);
    for (int i = 0; i < 30; i++) begin
      step_btn = ~step_btn;
      cycles(1);
    end
    step_btn = 1'b0;
    cycles(20);
    check("glitch_count", cycle_count, 32'd2);
    check("glitch_state", 32'(state), 32'd0);

    // Run: ticks at cycles 9,12,15,18; halting press lands on tick 21
    for (int i = 0; i < 4; i++) expect_pulse(2'b10);
    run_btn = 1'b1;
    cycles(5);
    run_btn = 1'b0;
    cycles(3);
    check("run_state", 32'(state), 32'd2);
    check("run_halted", 32'(halted), 32'd0);
    cycles(7);
    run_btn = 1'b1;
    cycles(5);
    run_btn = 1'b0;
    cycles(3);
    check("run_stop_state", 32'(state), 32'd0);
    cycles(30);
    check("run_stop_count", cycle_count, 32'd6);
    check("run_queue", exp_q.size(), 32'd0);

    // Breakpoint at 0x0005
    bp_enable = 1'b1;
    bp_addr   = 16'h0005;
    pc_base   = en_total;
    exp_pc    = 16'h0000;
    cycles(2);
    for (int i = 0; i < 5; i++) expect_pulse(2'b10);
    run_btn = 1'b1;
    cycles(5);
    run_btn = 1'b0;
    cycles(30);
    check("bp_state", 32'(state), 32'd3);
    check("bp_halted", 32'(halted), 32'd1);
    check("bp_pc", 32'(pc), 32'd5);
    check("bp_queue", exp_q.size(), 32'd0);

    // Resume from BREAK executes pc 5 without re-breaking
    for (int i = 0; i < 3; i++) expect_pulse(2'b10);
    run_btn = 1'b1;
    cycles(5);
    run_btn = 1'b0;
    cycles(7);
    run_btn = 1'b1;
    cycles(5);
    run_btn = 1'b0;
    cycles(20);
    check("resume_state", 32'(state), 32'd0);
    check("resume_pc", 32'(pc), 32'd8);
    check("resume_queue", exp_q.size(), 32'd0);

    // Break again, then step over the breakpoint instruction
    pc_base = en_total;
    exp_pc  = 16'h0000;
    cycles(2);
    for (int i = 0; i < 5; i++) expect_pulse(2'b10);
    run_btn = 1'b1;
    cycles(5);
    run_btn = 1'b0;
    cycles(30);
    check("bp2_state", 32'(state), 32'd3);
    expect_pulse(2'b01);
    step_btn = 1'b1;
    cycles(5);
    step_btn = 1'b0;
    cycles(20);
    check("bpstep_state", 32'(state), 32'd0);
    check("bpstep_pc", 32'(pc), 32'd6);
    check("bpstep_queue", exp_q.size(), 32'd0);

    // Reset asserted during a RUN tick cycle
    bp_enable = 1'b0;
    run_btn = 1'b1;
    cycles(5);
    run_btn = 1'b0;
    cycles(3);
    check("rst_run_state", 32'(state), 32'd2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_tick_cpu_en", 32'(cpu_en), 32'd0);
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", cycle_count, 32'd0);
    check("rst_halted", 32'(halted), 32'd1);
    reset   = 1'b0;
    exp_cnt = 32'd0;
    pc_base = en_total;
    exp_pc  = 16'h0000;
    cycles(3);

    // Simultaneous step and run in HALT: run wins
    for (int i = 0; i < 4; i++) expect_pulse(2'b10);
    step_btn = 1'b1;
    run_btn  = 1'b1;
    cycles(5);
    step_btn = 1'b0;
    run_btn  = 1'b0;
    cycles(2);
    check("both_state", 32'(state), 32'd2);
    cycles(8);
    run_btn = 1'b1;
    cycles(5);
    run_btn = 1'b0;
    cycles(10);
    check("both_stop_state", 32'(state), 32'd0);
    check("both_count", cycle_count, 32'd4);
    check("both_queue", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
